vec_op_sequencer: RTL and testbench

Controller that executes one element-wise vector instruction against the 16 x 5-element x 32-bit vector register file. It drives the file's two read addresses, buffers both source vectors, and computes one element per cycle through a single shared 32-bit ALU. It then issues one whole-vector write to the destination register. It sits between the decode/control path (start/op handshake) and the vector register file ports (va1/va2/vd2/wd2/we).

---
 rtl/vec_pkg.sv | 24 ++
 rtl/vec_elem_alu.sv | 30 +++
 rtl/vec_op_sequencer.sv | 123 ++++++++++++
 tb/tb_vec_op_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared constants, opcode encoding and FSM states for the vector op sequencer.
package vec_pkg;

    localparam int NUM_ELEMS = 5;
    localparam int DATA_W    = 32;
    localparam int REG_AW    = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_MIN = 3'b110;
    localparam logic [2:0] OP_MAX = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/vec_elem_alu.sv
// Combinational single-element ALU, shared across all vector elements.
module vec_elem_alu
    import vec_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);

    // Only the low half of the product is ever needed.
    logic [DATA_W-1:0] prod_lo;
    assign prod_lo = a * b;

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_ORR:  y = a | b;
            OP_EOR:  y = a ^ b;
            OP_MUL:  y = prod_lo;
            OP_MIN:  y = ($signed(a) < $signed(b)) ? a : b;
            OP_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/vec_op_sequencer.sv
// Sequences one element-wise vector instruction: read both sources, compute one
// element per cycle through a shared ALU, then write the whole result vector.
module vec_op_sequencer
    import vec_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [2:0]                  op,
    input  logic                        scalar_sel,
    input  logic [DATA_W-1:0]           scalar_in,
    input  logic [REG_AW-1:0]           src1_in,
    input  logic [REG_AW-1:0]           src2_in,
    input  logic [REG_AW-1:0]           dst_in,
    output logic                        busy,
    output logic                        done,
    output logic [NUM_ELEMS-1:0]        zero_mask,
    output logic [REG_AW-1:0]           va1,
    output logic [REG_AW-1:0]           va2,
    input  logic [DATA_W*NUM_ELEMS-1:0] vr1,
    input  logic [DATA_W*NUM_ELEMS-1:0] vr2,
    output logic [REG_AW-1:0]           vd2,
    output logic [DATA_W*NUM_ELEMS-1:0] wd2,
    output logic                        we
);

    localparam int IDX_W = $clog2(NUM_ELEMS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    state_t             state_reg;
    logic [2:0]         op_reg;
    logic               sel_reg;
    logic [DATA_W-1:0]  scalar_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [DATA_W-1:0]  a_reg   [NUM_ELEMS];
    logic [DATA_W-1:0]  b_reg   [NUM_ELEMS];
    logic [DATA_W-1:0]  res_reg [NUM_ELEMS];

    logic [DATA_W-1:0]  alu_b;
    logic [DATA_W-1:0]  alu_y;
    logic [NUM_ELEMS-1:0] res_zero;

    assign alu_b = sel_reg ? scalar_reg : b_reg[idx_reg];

    vec_elem_alu u_alu (
        .a  (a_reg[idx_reg]),
        .b  (alu_b),
        .op (op_reg),
        .y  (alu_y)
    );

    // Write data is a direct view of the result buffer, so it reads zero after reset.
    generate
        for (genvar gi = 0; gi < NUM_ELEMS; gi++) begin : g_pack
            assign wd2[gi*DATA_W +: DATA_W] = res_reg[gi];
            assign res_zero[gi] = (res_reg[gi] == '0);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            sel_reg    <= 1'b0;
            scalar_reg <= '0;
            idx_reg    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            we         <= 1'b0;
            va1        <= '0;
            va2        <= '0;
            vd2        <= '0;
            zero_mask  <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                a_reg[i]   <= '0;
                b_reg[i]   <= '0;
                res_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg     <= op;
                        sel_reg    <= scalar_sel;
                        scalar_reg <= scalar_in;
                        va1        <= src1_in;
                        va2        <= src2_in;
                        vd2        <= dst_in;
                        busy       <= 1'b1;
                        state_reg  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Buffering here makes dst/src aliasing see pre-write values.
                    for (int i = 0; i < NUM_ELEMS; i++) begin
                        a_reg[i] <= vr1[i*DATA_W +: DATA_W];
                        b_reg[i] <= vr2[i*DATA_W +: DATA_W];
                    end
                    idx_reg   <= '0;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    res_reg[idx_reg] <= alu_y;
                    idx_reg          <= idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        we        <= 1'b1;
                        done      <= 1'b1;
                        state_reg <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    we        <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    zero_mask <= res_zero;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_op_sequencer.sv
// Self-checking bench: behavioural register file, directed table, random ops, corner sequences.
module tb_vec_op_sequencer;
    import vec_pkg::*;

    typedef logic [DATA_W*NUM_ELEMS-1:0] vec_t;

    typedef struct {
        string          name;
        logic [2:0]     op;
        logic           sel;
        logic [31:0]    scalar;
        vec_t           a;
        vec_t           b;
        vec_t           exp_v;
        logic [4:0]     exp_zm;
    } vec_case_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [2:0]           op = '0;
    logic                 scalar_sel = 1'b0;
    logic [31:0]          scalar_in = '0;
    logic [3:0]           src1_in = '0, src2_in = '0, dst_in = '0;
    logic                 busy, done, we;
    logic [4:0]           zero_mask;
    logic [3:0]           va1, va2, vd2;
    vec_t                 vr1, vr2, wd2;

    vec_t                 rf [16];
    logic                 pl_we = 1'b0;
    logic [3:0]           pl_addr = '0;
    vec_t                 pl_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vec_op_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .scalar_sel (scalar_sel),
        .scalar_in  (scalar_in),
        .src1_in    (src1_in),
        .src2_in    (src2_in),
        .dst_in     (dst_in),
        .busy       (busy),
        .done       (done),
        .zero_mask  (zero_mask),
        .va1        (va1),
        .va2        (va2),
        .vr1        (vr1),
        .vr2        (vr2),
        .vd2        (vd2),
        .wd2        (wd2),
        .we         (we)
    );

    // Register file model: combinational read, write on the clock edge.
    assign vr1 = rf[va1];
    assign vr2 = rf[va2];
    always @(posedge clk) begin
        if (we) rf[vd2] <= wd2;
        else if (pl_we) rf[pl_addr] <= pl_data;
    end

    function automatic vec_t mk(input logic [31:0] e0, e1, e2, e3, e4);
        return {e4, e3, e2, e1, e0};
    endfunction

    // Reference: apply the operation to each element pair with plain arithmetic.
    function automatic vec_t model(input logic [2:0] o, input vec_t a, input vec_t b,
                                   input logic sel, input logic [31:0] sc);
        vec_t r;
        r = '0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            logic [31:0] x, y, z;
            logic [63:0] p;
            longint sx, sy;
            x  = a[i*32 +: 32];
            y  = sel ? sc : b[i*32 +: 32];
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = {32'd0, x} * {32'd0, y};
            case (o)
                OP_ADD:  z = 32'(({32'd0, x} + {32'd0, y}) % 64'h1_0000_0000);
                OP_SUB:  z = 32'(({32'd1, x} - {32'd0, y}) % 64'h1_0000_0000);
                OP_AND:  z = x & y;
                OP_ORR:  z = x | y;
                OP_EOR:  z = x ^ y;
                OP_MUL:  z = p[31:0];
                OP_MIN:  z = (sx <= sy) ? x : y;
                default: z = (sx >= sy) ? x : y;
            endcase
            r[i*32 +: 32] = z;
        end
        return r;
    endfunction

    function automatic logic [4:0] zmask_of(input vec_t v);
        logic [4:0] m;
        for (int i = 0; i < NUM_ELEMS; i++) m[i] = (v[i*32 +: 32] == 32'd0);
        return m;
    endfunction

    task automatic chk(input string name, input vec_t act, input vec_t exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic preload(input logic [3:0] addr, input vec_t data);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = addr; pl_data = data;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Issue one instruction and watch up to 12 cycles after the accepting edge.
    // extra_k > 0 re-asserts start in that cycle to prove it is ignored.
    task automatic run_op(input string name, input logic [2:0] o, input logic sel,
                          input logic [31:0] sc, input logic [3:0] s1, s2, d,
                          input vec_t exp_v, input logic [4:0] exp_zm, input int extra_k);
        int we_cycle, we_count, busy_fall, done_bad;
        we_cycle = -1; we_count = 0; busy_fall = -1; done_bad = 0;
        @(negedge clk);
        start = 1'b1; op = o; scalar_sel = sel; scalar_in = sc;
        src1_in = s1; src2_in = s2; dst_in = d;
        @(posedge clk); #1;
        chk({name, " busy_on_accept"}, vec_t'(busy), vec_t'(1'b1));
        chk({name, " va1"}, vec_t'(va1), vec_t'(s1));
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = (k == extra_k);
            op = $urandom; src1_in = $urandom; dst_in = $urandom;
            @(posedge clk); #1;
            if (done !== we) done_bad++;
            if (we === 1'b1) begin
                we_count++;
                if (we_cycle < 0) begin
                    we_cycle = k;
                    chk({name, " wd2"}, wd2, exp_v);
                    chk({name, " vd2"}, vec_t'(vd2), vec_t'(d));
                end
            end
            if (busy === 1'b0 && busy_fall < 0) busy_fall = k;
        end
        start = 1'b0;
        chk({name, " we_cycle"}, vec_t'(we_cycle), vec_t'(6));
        chk({name, " we_count"}, vec_t'(we_count), vec_t'(1));
        chk({name, " busy_fall"}, vec_t'(busy_fall), vec_t'(7));
        chk({name, " done_eq_we"}, vec_t'(done_bad), vec_t'(0));
        chk({name, " busy_end"}, vec_t'(busy), vec_t'(1'b0));
        chk({name, " rf_dst"}, rf[d], exp_v);
        chk({name, " zero_mask"}, vec_t'(zero_mask), vec_t'(exp_zm));
        $display("txn %s op=%0d sel=%0d dst=%0d result=%h zmask=%b", name, o, sel, d, rf[d], zero_mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_case_t tbl [4];
        vec_t old_v, ev;

        tbl[0] = '{"add", OP_ADD, 1'b0, 32'd0, mk(1,2,3,4,5), mk(10,20,30,40,50),
                   mk(11,22,33,44,55), 5'b00000};
        tbl[1] = '{"sub_wrap", OP_SUB, 1'b0, 32'd0, mk(0,5,7,0,1), mk(1,5,7,0,2),
                   mk(32'hFFFFFFFF,0,0,0,32'hFFFFFFFF), 5'b01110};
        tbl[2] = '{"mul_scalar", OP_MUL, 1'b1, 32'h10000, mk(2,32'hFFFFFFFD,32'h10000,7,1),
                   mk(9,9,9,9,9), mk(32'h20000,32'hFFFD0000,0,32'h70000,32'h10000), 5'b00100};
        tbl[3] = '{"min_scalar", OP_MIN, 1'b1, 32'd0, mk(2,32'hFFFFFFFD,32'h10000,7,1),
                   mk(9,9,9,9,9), mk(0,32'hFFFFFFFD,0,0,0), 5'b11101};

        for (int i = 0; i < 16; i++) rf[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", vec_t'(busy), '0);
        chk("rst done", vec_t'(done), '0);
        chk("rst we", vec_t'(we), '0);
        chk("rst addrs", vec_t'({va1, va2, vd2}), '0);
        chk("rst wd2", wd2, '0);
        chk("rst zero_mask", vec_t'(zero_mask), '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            preload(4'd1, tbl[i].a);
            preload(4'd2, tbl[i].b);
            run_op(tbl[i].name, tbl[i].op, tbl[i].sel, tbl[i].scalar, 4'd1, 4'd2, 4'd3,
                   tbl[i].exp_v, tbl[i].exp_zm, 0);
        end

        // Aliasing with an ignored start during EXEC, then back-to-back acceptance
        preload(4'd1, mk(1,1,1,1,1));
        run_op("alias_busy", OP_ADD, 1'b0, 32'd0, 4'd1, 4'd1, 4'd1, mk(2,2,2,2,2), 5'b00000, 3);
        run_op("after_busy", OP_MAX, 1'b0, 32'd0, 4'd1, 4'd2, 4'd4,
               model(OP_MAX, rf[1], rf[2], 1'b0, 32'd0),
               zmask_of(model(OP_MAX, rf[1], rf[2], 1'b0, 32'd0)), 0);

        // Reset in the third EXEC cycle
        preload(4'd5, mk(32'hAAAA,32'hBBBB,32'hCCCC,32'hDDDD,32'hEEEE));
        old_v = rf[5];
        @(negedge clk);
        start = 1'b1; op = OP_EOR; scalar_sel = 1'b0; src1_in = 4'd1; src2_in = 4'd2; dst_in = 4'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst busy", vec_t'(busy), '0);
        chk("midrst done", vec_t'(done), '0);
        chk("midrst we", vec_t'(we), '0);
        chk("midrst wd2", wd2, '0);
        chk("midrst zero_mask", vec_t'(zero_mask), '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("midrst dst_kept", rf[5], old_v);
        $display("txn midrst dst=5 value=%h", rf[5]);
        ev = model(OP_EOR, rf[1], rf[2], 1'b0, 32'd0);
        run_op("post_reset", OP_EOR, 1'b0, 32'd0, 4'd1, 4'd2, 4'd5, ev, zmask_of(ev), 0);

        // Random instructions against the reference model
        for (int n = 0; n < 20; n++) begin
            logic [3:0] s1, s2, d;
            logic [2:0] o;
            logic sel;
            logic [31:0] sc;
            vec_t va, vb;
            s1 = 4'($urandom); s2 = 4'($urandom); d = 4'($urandom);
            o = 3'($urandom); sel = ($urandom_range(3) == 0);
            sc = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                va[i*32 +: 32] = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
                vb[i*32 +: 32] = ($urandom_range(3) == 0) ? va[i*32 +: 32] : $urandom;
            end
            preload(s1, va);
            preload(s2, vb);
            ev = model(o, rf[s1], rf[s2], sel, sc);
            run_op($sformatf("rand%0d", n), o, sel, sc, s1, s2, d, ev, zmask_of(ev), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
